// File: rtl/mul_iterative.sv
// Iterative shift-add multiplier execute unit (RV M-extension multiply uops).
// Retires p_bits_per_cycle multiplier bits per compute cycle and returns the
// selected half of the full 2W-bit product on the X->W interface.

package mul_iterative_pkg;
    typedef enum logic [3:0] {
        OP_ADD    = 4'd0,
        OP_SUB    = 4'd1,
        OP_MUL    = 4'd2,
        OP_MULH   = 4'd3,
        OP_MULHSU = 4'd4,
        OP_MULHU  = 4'd5
    } rv_uop;
endpackage

module mul_iterative
    import mul_iterative_pkg::*;
#(
    parameter int p_addr_bits      = 32,
    parameter int p_data_bits      = 32,
    parameter int p_seq_num_bits   = 5,
    parameter int p_bits_per_cycle = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    // D -> X request
    input  logic                      d_val,
    output logic                      d_rdy,
    input  logic [p_addr_bits-1:0]    d_pc,
    input  logic [p_seq_num_bits-1:0] d_seq_num,
    input  logic [p_data_bits-1:0]    d_op1,
    input  logic [p_data_bits-1:0]    d_op2,
    input  logic [4:0]                d_waddr,
    input  rv_uop                     d_uop,
    // X -> W result
    output logic                      w_val,
    input  logic                      w_rdy,
    output logic [p_addr_bits-1:0]    w_pc,
    output logic [p_seq_num_bits-1:0] w_seq_num,
    output logic [4:0]                w_waddr,
    output logic [p_data_bits-1:0]    w_wdata,
    output logic                      w_wen
);

    localparam int W  = p_data_bits;
    localparam int W2 = 2 * p_data_bits;
    localparam int K  = p_bits_per_cycle;
    localparam int N  = W / K;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [W-1:0]  ONE_W    = W'(1'b1);
    localparam logic [W2-1:0] ONE_W2   = W2'(1'b1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    state_r;
    state_t                    state_s;
    logic                      d_rdy_s;
    logic                      accept_s;
    logic                      last_s;

    // Datapath state
    logic [CW-1:0]             cnt_r;
    logic [W2-1:0]             acc_r;
    logic [W2-1:0]             mcand_r;
    logic [W-1:0]              mplier_r;
    logic                      neg_r;
    rv_uop                     uop_r;

    // Operand preparation at accept
    logic                      op1_signed_s;
    logic                      op2_signed_s;
    logic                      sign1_s;
    logic                      sign2_s;
    logic [W-1:0]              mag1_s;
    logic [W-1:0]              mag2_s;

    // Step and result selection
    logic [W2-1:0]             acc_next_s;
    logic [W2-1:0]             prod_s;
    logic [W-1:0]              wdata_s;

    // Registered W-side outputs
    logic                      w_val_r;
    logic                      w_wen_r;
    logic [p_addr_bits-1:0]    w_pc_r;
    logic [p_seq_num_bits-1:0] w_seq_num_r;
    logic [4:0]                w_waddr_r;
    logic [W-1:0]              w_wdata_r;

    assign d_rdy     = d_rdy_s;
    assign w_val     = w_val_r;
    assign w_wen     = w_wen_r;
    assign w_pc      = w_pc_r;
    assign w_seq_num = w_seq_num_r;
    assign w_waddr   = w_waddr_r;
    assign w_wdata   = w_wdata_r;

    // Signedness of each incoming operand and its unsigned magnitude.
    always_comb begin
        op1_signed_s = 1'b1;
        op2_signed_s = 1'b1;
        case (d_uop)
            OP_MULHSU: begin
                op1_signed_s = 1'b1;
                op2_signed_s = 1'b0;
            end
            OP_MULHU: begin
                op1_signed_s = 1'b0;
                op2_signed_s = 1'b0;
            end
            default: begin
                op1_signed_s = 1'b1;
                op2_signed_s = 1'b1;
            end
        endcase
        sign1_s = op1_signed_s & d_op1[W-1];
        sign2_s = op2_signed_s & d_op2[W-1];
        // W-bit negate keeps abs(-2^(W-1)) exact as an unsigned magnitude.
        if (sign1_s) begin
            mag1_s = ~d_op1 + ONE_W;
        end else begin
            mag1_s = d_op1;
        end
        if (sign2_s) begin
            mag2_s = ~d_op2 + ONE_W;
        end else begin
            mag2_s = d_op2;
        end
    end

    // One shift-add step, plus the sign fix-up and half select used on the last step.
    always_comb begin
        acc_next_s = acc_r + (mcand_r * W2'(mplier_r[K-1:0]));
        if (neg_r) begin
            prod_s = ~acc_next_s + ONE_W2;
        end else begin
            prod_s = acc_next_s;
        end
        case (uop_r)
            OP_MULH, OP_MULHSU, OP_MULHU: wdata_s = prod_s[W2-1:W];
            default:                      wdata_s = prod_s[W-1:0];
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next state, accept strobe and D-side ready.
    always_comb begin
        state_s  = state_r;
        d_rdy_s  = 1'b0;
        accept_s = 1'b0;
        last_s   = (cnt_r == CNT_LAST);
        case (state_r)
            IDLE: begin
                d_rdy_s = 1'b1;
                if (d_val) begin
                    accept_s = 1'b1;
                    state_s  = CALC;
                end else begin
                    state_s  = IDLE;
                end
            end
            CALC: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = CALC;
                end
            end
            DONE: begin
                // Ready for a new op only in the cycle the result is taken.
                d_rdy_s = w_rdy;
                if (w_rdy) begin
                    if (d_val) begin
                        accept_s = 1'b1;
                        state_s  = CALC;
                    end else begin
                        state_s  = IDLE;
                    end
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Operand capture, shift-add iteration and registered result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r       <= {CW{1'b0}};
            acc_r       <= {W2{1'b0}};
            mcand_r     <= {W2{1'b0}};
            mplier_r    <= {W{1'b0}};
            neg_r       <= 1'b0;
            uop_r       <= OP_ADD;
            w_val_r     <= 1'b0;
            w_wen_r     <= 1'b0;
            w_pc_r      <= {p_addr_bits{1'b0}};
            w_seq_num_r <= {p_seq_num_bits{1'b0}};
            w_waddr_r   <= 5'd0;
            w_wdata_r   <= {W{1'b0}};
        end else if (accept_s) begin
            cnt_r       <= {CW{1'b0}};
            acc_r       <= {W2{1'b0}};
            mcand_r     <= W2'(mag1_s);
            mplier_r    <= mag2_s;
            neg_r       <= sign1_s ^ sign2_s;
            uop_r       <= d_uop;
            w_val_r     <= 1'b0;
            w_wen_r     <= 1'b0;
            w_pc_r      <= d_pc;
            w_seq_num_r <= d_seq_num;
            w_waddr_r   <= d_waddr;
        end else if (state_r == CALC) begin
            acc_r    <= acc_next_s;
            mcand_r  <= mcand_r << K;
            mplier_r <= mplier_r >> K;
            cnt_r    <= cnt_r + CNT_ONE;
            if (last_s) begin
                w_wdata_r <= wdata_s;
                w_val_r   <= 1'b1;
                w_wen_r   <= 1'b1;
            end
        end else if ((state_r == DONE) && w_rdy) begin
            w_val_r <= 1'b0;
            w_wen_r <= 1'b0;
        end
    end

endmodule
